// File: rtl/regfile_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_pkg : shared widths and write-request type for the RF writeback path
// Rev 1.0
// ------------------------------------------------------------------
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_wr_arbiter_if : two writeback request channels plus the RF write port
// Rev 1.0
// ------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) ();

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter with a single priority flop
// Rev 1.0
// ------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic prio_q;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Priority moves to the requester that just lost; holds when idle.
  always_ff @(posedge clk) begin
    if (rst)           prio_q <= 1'b0;
    else if (grant[0]) prio_q <= 1'b1;
    else if (grant[1]) prio_q <= 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_wr_arbiter : buffers ALU/load writebacks and merges them onto one RF write port
// Rev 1.0
// ------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wr_arbiter_if.slave bus,
  input  logic [ADDR_W-1:0]   rd_addrA,
  input  logic [ADDR_W-1:0]   rd_addrB,
  output logic                pend_hitA,
  output logic                pend_hitB,
  output logic [15:0]         conflict_cnt
);
  import regfile_pkg::*;

  logic [1:0]        in_valid;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        ready;
  logic [1:0]        buf_valid;
  logic [ADDR_W-1:0] buf_addr [2];
  logic [DATA_W-1:0] buf_data [2];
  logic [1:0]        grant;
  logic [1:0]        arb_req;
  logic [15:0]       cnt_q;

  assign in_valid   = {bus.req1_valid, bus.req0_valid};
  assign in_addr[0] = bus.req0_addr;
  assign in_addr[1] = bus.req1_addr;
  assign in_data[0] = bus.req0_data;
  assign in_data[1] = bus.req1_data;

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];

  for (genvar i = 0; i < 2; i++) begin : g_buf
    logic    valid_q;
    wr_req_t entry_q;
    logic    load;

    assign ready[i] = ~rst & (~valid_q | grant[i]);
    // Writes to the zero register are acknowledged but dropped here.
    assign load     = in_valid[i] & ready[i] & (in_addr[i] != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        entry_q <= '{addr: in_addr[i], data: in_data[i]};
      end else if (grant[i]) begin
        valid_q <= 1'b0;
      end
    end

    assign buf_valid[i] = valid_q;
    assign buf_addr[i]  = entry_q.addr;
    assign buf_data[i]  = entry_q.data;
  end

  // Masking with rst keeps stale buffers from writing in the reset cycle.
  assign arb_req = buf_valid & {2{~rst}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .grant (grant)
  );

  assign bus.rf_wr_en   = |grant;
  assign bus.rf_wr_addr = grant[0] ? buf_addr[0] : (grant[1] ? buf_addr[1] : '0);
  assign bus.rf_wr_data = grant[0] ? buf_data[0] : (grant[1] ? buf_data[1] : '0);

  assign pend_hitA = ~rst & (rd_addrA != '0) &
                     ((buf_valid[0] & (buf_addr[0] == rd_addrA)) |
                      (buf_valid[1] & (buf_addr[1] == rd_addrA)));
  assign pend_hitB = ~rst & (rd_addrB != '0) &
                     ((buf_valid[0] & (buf_addr[0] == rd_addrB)) |
                      (buf_valid[1] & (buf_addr[1] == rd_addrB)));

  always_ff @(posedge clk) begin
    if (rst)                                 cnt_q <= 16'd0;
    else if (&buf_valid && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 5, register address width (32 registers).
REQ-002 Parameter: DATA_W, default 32, register data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) write request.
REQ-006 req0_addr  input  ADDR_W  requester 0 destination register.
REQ-007 req0_data  input  DATA_W  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 request accepted this cycle when valid and ready are both high.
REQ-009 req1_valid, req1_addr, req1_data, req1_ready  as REQ-005..008, for requester 1 (load writeback).
REQ-010 rf_wr_en  output  1  register-file write enable.
REQ-011 rf_wr_addr  output  ADDR_W  register-file write address.
REQ-012 rf_wr_data  output  DATA_W  register-file write data.
REQ-013 rd_addrA, rd_addrB  input  ADDR_W  register-file read addresses, snooped for hazards.
REQ-014 pend_hitA, pend_hitB  output  1  a buffered, not-yet-written value targets rd_addrA / rd_addrB.
REQ-015 conflict_cnt  output  16  count of cycles in which both buffers were valid.

Function
REQ-016 One single-entry buffer (valid, addr, data) per requester; load on valid&ready.
REQ-017 reqN_ready = ~rst & (~bufN_valid | grantN): a buffer accepts a new request in the cycle it drains.
REQ-018 Grant: one buffer valid -> grant it; both valid -> grant the requester selected by the round-robin pointer prio.
REQ-019 prio: after a grant to requester k, prio becomes ~k; prio is unchanged when there is no grant.
REQ-020 rf_wr_en = 1 exactly when a grant exists; rf_wr_addr/rf_wr_data come from the granted buffer via mux only, with no extra register stage.
REQ-021 Latency: a request accepted at edge N is presented on rf_wr_* in cycle N+1 at the earliest; with no contention this is exactly N+1.
REQ-022 Address 0: a request with addr 0 is accepted (ready per REQ-017) but never loaded or written; rf_wr_en never asserts with addr 0.
REQ-023 A granted buffer clears at the next edge unless reloaded the same cycle by REQ-017.
REQ-024 When rf_wr_en is low, rf_wr_addr and rf_wr_data are 0.
REQ-025 Same-address writes from both requesters are issued in grant order; the later grant's data is the final register value.
REQ-026 pend_hitX = 1 when rd_addrX != 0 and equals the addr of any valid buffer, including the one being granted this cycle.
REQ-027 conflict_cnt increments by 1 each cycle both buffers are valid and saturates at 16'hFFFF.
REQ-028 Worst-case wait: a valid buffer is granted within 2 cycles (no starvation).

Reset
REQ-029 While rst is high at an edge: both buffers invalid, prio = 0, conflict_cnt = 0.
REQ-030 During rst: req0_ready = req1_ready = 0, rf_wr_en = 0, pend_hitA = pend_hitB = 0.
REQ-031 Reset mid-operation discards buffered writes; no rf write is issued in the reset cycle or after it for those writes.

Structure
REQ-032 Shared package regfile_pkg holds ADDR_W, DATA_W, NUM_REGS = 32, ZERO_REG = 0 and the write-request struct {addr, data}.
REQ-033 A single sub-module rr_arb2 (2-way round-robin: req[1:0], prio flop -> grant[1:0]) is instantiated once.

Verification
REQ-034 After rst, req0 writes addr 5 data 32'hDEADBEEF at edge N -> rf_wr_en=1, addr 5, data DEADBEEF in cycle N+1; ready stays 1.
REQ-035 req0 (addr 3, data 32'h11) and req1 (addr 3, data 32'h22) accepted at the same edge -> writes 32'h11 then 32'h22 in consecutive cycles (prio=0); conflict_cnt=1.
REQ-036 Both requesters held continuously valid for 8 cycles -> grants alternate 0,1,0,1...; each ready is high every second cycle.
REQ-037 req1 writes addr 0 data 32'hFFFF_FFFF -> req1_ready=1, rf_wr_en stays 0, pend_hitA=0 with rd_addrA=0.
REQ-038 Buffered write to addr 7 with rd_addrA=7, rd_addrB=8 -> pend_hitA=1, pend_hitB=0 until the write issues.
REQ-039 rst asserted for 1 cycle while both buffers are valid -> no rf write in that or any later cycle for them; prio=0; conflict_cnt=0.
